// File: rtl/fp_div_seq.sv
// Sequential restoring radix-2 fixed-point divider c = a / b, one quotient bit per clk, valid/ready both sides.
// Optional build macro FP_DIV_ROUND_EN: round half away from zero (adds one clk of latency).
module fp_div_seq #(
  parameter int i1 = 2,
  parameter int f1 = 14,
  parameter int i2 = 2,
  parameter int f2 = 14,
  parameter int i3 = 2,
  parameter int f3 = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [i1+f1-1:0] a,
  input  logic             s1,
  input  logic [i2+f2-1:0] b,
  input  logic             s2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [i3+f3-1:0] c,
  output logic             sign,
  output logic             overflow,
  output logic             underflow,
  output logic             div_by_zero
);

  localparam int AW   = i1 + f1;
  localparam int BW   = i2 + f2;
  localparam int CW   = i3 + f3;
  localparam int NW   = i1 + f2 + f3;
  localparam int SH   = f2 + f3 - f1;
  localparam int CNTW = (NW > 1) ? $clog2(NW) : 1;
  localparam int QW   = ((NW > CW) ? NW : CW) + 1;

  generate
    if (f2 + f3 < f1) begin : g_fmt_check
      $error("fp_div_seq: f2+f3 must be >= f1");
    end
  endgenerate

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CALC = 3'd1;
`ifdef FP_DIV_ROUND_EN
  localparam logic [2:0] ST_RND  = 3'd2;
`endif
  localparam logic [2:0] ST_FIN  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [2:0]      state;
  logic [CNTW-1:0] cnt;
  logic [NW-1:0]   nq;     // numerator bits shift out the top, quotient bits shift in at the bottom
  logic [BW:0]     rem;
  logic [BW:0]     bmag;
  logic            neg;
  logic            a_nz;
  logic            dz;

  logic [AW:0]     amag_c;
  logic [BW:0]     bmag_c;
  logic [BW+1:0]   trial;
  logic            fits;
  logic [BW:0]     diff;
  logic [QW-1:0]   q_ext;
  logic [QW-1:0]   lim_u;
  logic [QW-1:0]   lim_p;
  logic [QW-1:0]   lim_n;
  logic [CW-1:0]   res_c;
  logic            res_ov;
  logic            res_un;

  assign in_ready  = (state == ST_IDLE) && !rst;
  assign out_valid = (state == ST_DONE);

  // Magnitudes are one bit wider than the operands so the signed minimum does not wrap.
  always_comb begin
    amag_c = {1'b0, a};
    bmag_c = {1'b0, b};
    if (s1 && a[AW-1]) amag_c = -{a[AW-1], a};
    if (s2 && b[BW-1]) bmag_c = -{b[BW-1], b};
  end

  always_comb begin
    trial = {rem, nq[NW-1]};
    fits  = (trial >= {1'b0, bmag});
    diff  = trial[BW:0] - bmag;
  end

  always_comb begin
    q_ext  = QW'(nq);
    lim_u  = (QW'(1) << CW) - QW'(1);
    lim_p  = (QW'(1) << (CW - 1)) - QW'(1);
    lim_n  = QW'(1) << (CW - 1);
    res_c  = '0;
    res_ov = 1'b0;
    res_un = 1'b0;
    if (dz) begin
      if (!sign)    res_c = {CW{1'b1}};
      else if (neg) res_c = {1'b1, {(CW-1){1'b0}}};
      else          res_c = {1'b0, {(CW-1){1'b1}}};
    end else begin
      res_un = a_nz && (q_ext == '0);
      if (!sign) begin
        if (q_ext > lim_u) begin
          res_ov = 1'b1;
          res_c  = {CW{1'b1}};
        end else begin
          res_c  = q_ext[CW-1:0];
        end
      end else if (!neg) begin
        if (q_ext > lim_p) begin
          res_ov = 1'b1;
          res_c  = {1'b0, {(CW-1){1'b1}}};
        end else begin
          res_c  = q_ext[CW-1:0];
        end
      end else begin
        if (q_ext > lim_n) begin
          res_ov = 1'b1;
          res_c  = {1'b1, {(CW-1){1'b0}}};
        end else begin
          res_c  = ~q_ext[CW-1:0] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      nq          <= '0;
      rem         <= '0;
      bmag        <= '0;
      neg         <= 1'b0;
      a_nz        <= 1'b0;
      dz          <= 1'b0;
      c           <= '0;
      sign        <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            nq    <= NW'(amag_c) << SH;
            rem   <= '0;
            bmag  <= bmag_c;
            neg   <= (s1 & a[AW-1]) ^ (s2 & b[BW-1]);
            sign  <= s1 | s2;
            a_nz  <= (a != '0);
            dz    <= (b == '0);
            cnt   <= CNTW'(NW - 1);
            // A zero divisor skips the iterations and is saturated in FIN.
            state <= (b == '0) ? ST_FIN : ST_CALC;
          end
        end
        ST_CALC: begin
          rem <= fits ? diff : trial[BW:0];
          nq  <= {nq[NW-2:0], fits};
          cnt <= cnt - CNTW'(1);
          if (cnt == '0) begin
`ifdef FP_DIV_ROUND_EN
            state <= ST_RND;
`else
            state <= ST_FIN;
`endif
          end
        end
`ifdef FP_DIV_ROUND_EN
        ST_RND: begin
          if ({rem, 1'b0} >= {1'b0, bmag}) nq <= nq + NW'(1);
          state <= ST_FIN;
        end
`endif
        ST_FIN: begin
          c           <= res_c;
          overflow    <= res_ov;
          underflow   <= res_un;
          div_by_zero <= dz;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
